// File: rtl/apb_master_arb.sv
// Two-requester round-robin APB master: arbitrates REQ0/REQ1, runs SETUP/ACCESS,
// returns read data and status, and force-terminates transfers a slave stalls on.
module apb_master_arb #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic [11:0] ADDR0,
  input  logic [11:0] ADDR1,
  input  logic        WRITE0,
  input  logic        WRITE1,
  input  logic [31:0] WDATA0,
  input  logic [31:0] WDATA1,
  input  logic [3:0]  STRB0,
  input  logic [3:0]  STRB1,
  output logic        ACK0,
  output logic        ACK1,
  output logic [31:0] RDATA0,
  output logic [31:0] RDATA1,
  output logic        ERR0,
  output logic        ERR1,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [11:0] PADDR,
  output logic [31:0] PWDATA,
  output logic [3:0]  PSTRB,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  output logic [1:0]  GRANT
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  state_t      state;
  logic        last;
  logic [7:0]  wait_cnt;
  logic        win1;
  logic        timeout_hit;
  logic        sel_write;
  logic [11:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_strb;
  logic        done_err;
  logic [31:0] done_rdata;

  // Requester 1 wins if it is alone, or on a tie when it was not the last owner.
  function automatic logic pick_req1(input logic r0, input logic r1, input logic lst);
    return r1 && (!r0 || !lst);
  endfunction

  always_comb begin
    win1        = pick_req1(REQ0, REQ1, last);
    sel_write   = win1 ? WRITE1 : WRITE0;
    sel_addr    = win1 ? ADDR1  : ADDR0;
    sel_wdata   = win1 ? WDATA1 : WDATA0;
    sel_strb    = sel_write ? (win1 ? STRB1 : STRB0) : 4'h0;
    timeout_hit = (TIMEOUT_W != 8'd0) && (wait_cnt == TIMEOUT_W);
    // A slave response takes priority; a forced end reports an error and zero data.
    done_err    = PREADY ? PSLVERR : 1'b1;
    done_rdata  = PREADY ? PRDATA  : 32'h0;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= IDLE;
      last     <= 1'b1;
      wait_cnt <= 8'd0;
      PSEL     <= 1'b0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= 12'h0;
      PWDATA   <= 32'h0;
      PSTRB    <= 4'h0;
      GRANT    <= 2'b00;
      ACK0     <= 1'b0;
      ACK1     <= 1'b0;
      ERR0     <= 1'b0;
      ERR1     <= 1'b0;
      RDATA0   <= 32'h0;
      RDATA1   <= 32'h0;
    end else begin
      ACK0 <= 1'b0;
      ACK1 <= 1'b0;
      ERR0 <= 1'b0;
      ERR1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (REQ0 || REQ1) begin
            state    <= SETUP;
            PSEL     <= 1'b1;
            PENABLE  <= 1'b0;
            wait_cnt <= 8'd0;
            last     <= win1;
            GRANT    <= win1 ? 2'b10 : 2'b01;
            PADDR    <= sel_addr;
            PWRITE   <= sel_write;
            PWDATA   <= sel_wdata;
            PSTRB    <= sel_strb;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY || timeout_hit) begin
            state   <= IDLE;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            GRANT   <= 2'b00;
            ACK0    <= GRANT[0];
            ACK1    <= GRANT[1];
            ERR0    <= GRANT[0] & done_err;
            ERR1    <= GRANT[1] & done_err;
            if (!PWRITE && GRANT[0]) RDATA0 <= done_rdata;
            if (!PWRITE && GRANT[1]) RDATA1 <= done_rdata;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// Bench for apb_master_arb: directed scenarios then randomized transfers checked
// against a transaction-level round-robin/APB timing model.
module tb_apb_master_arb;
  localparam int TO = 4;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        REQ0 = 1'b0, REQ1 = 1'b0;
  logic [11:0] ADDR0 = '0, ADDR1 = '0;
  logic        WRITE0 = 1'b0, WRITE1 = 1'b0;
  logic [31:0] WDATA0 = '0, WDATA1 = '0;
  logic [3:0]  STRB0 = '0, STRB1 = '0;
  logic        ACK0, ACK1, ERR0, ERR1;
  logic [31:0] RDATA0, RDATA1;
  logic        PSEL, PENABLE, PWRITE;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0, PSLVERR = 1'b0;
  logic [1:0]  GRANT;

  int          n_tests = 0;
  int          n_fail = 0;
  int          last_m;
  logic [31:0] rd_m [2];
  int          won;
  int          order [4];

  apb_master_arb #(.TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .REQ0(REQ0), .REQ1(REQ1), .ADDR0(ADDR0), .ADDR1(ADDR1),
    .WRITE0(WRITE0), .WRITE1(WRITE1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .STRB0(STRB0), .STRB1(STRB1),
    .ACK0(ACK0), .ACK1(ACK1), .RDATA0(RDATA0), .RDATA1(RDATA1),
    .ERR0(ERR0), .ERR1(ERR1),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .GRANT(GRANT)
  );

  always #5 PCLK = ~PCLK;

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transfer, starting with the current REQ/payload being sampled
  // at the next edge. waits = PREADY-low ACCESS cycles the slave inserts.
  task automatic run_xfer(input int waits, input logic slverr, input logic [31:0] prd,
                          output int w);
    logic [11:0] a;
    logic        wr;
    logic [31:0] wd;
    logic [3:0]  sb;
    int          fire;
    logic        timed;
    if (REQ0 && REQ1) w = (last_m == 0) ? 1 : 0;
    else              w = REQ1 ? 1 : 0;
    last_m = w;
    a  = w ? ADDR1  : ADDR0;
    wr = w ? WRITE1 : WRITE0;
    wd = w ? WDATA1 : WDATA0;
    sb = wr ? (w ? STRB1 : STRB0) : 4'h0;
    timed = (waits > TO);
    fire  = timed ? TO : waits;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
    step();
    chk("setup_grant", GRANT, (w == 1) ? 2'b10 : 2'b01);
    chk("setup_psel_pen", {PSEL, PENABLE}, 2'b10);
    chk("setup_paddr", PADDR, a);
    chk("setup_pwrite", PWRITE, wr);
    chk("setup_pwdata", PWDATA, wd);
    chk("setup_pstrb", PSTRB, sb);
    chk("setup_noack", {ACK0, ACK1}, 2'b00);
    if (w == 1) begin ADDR1 = 12'($urandom); WDATA1 = $urandom; STRB1 = 4'($urandom); end
    else        begin ADDR0 = 12'($urandom); WDATA0 = $urandom; STRB0 = 4'($urandom); end
    step();
    chk("access_psel_pen", {PSEL, PENABLE}, 2'b11);
    for (int c = 0; c < fire; c++) begin
      step();
      chk("wait_ctl", {PSEL, PENABLE, ACK0, ACK1}, 4'b1100);
      chk("wait_payload", {PADDR, PWDATA, PSTRB}, {a, wd, sb});
    end
    PREADY = !timed; PSLVERR = slverr; PRDATA = prd;
    step();
    if (!wr) rd_m[w] = timed ? 32'h0 : prd;
    chk("ack0", ACK0, (w == 0));
    chk("ack1", ACK1, (w == 1));
    chk("err0", ERR0, (w == 0) && (timed || slverr));
    chk("err1", ERR1, (w == 1) && (timed || slverr));
    chk("rdata0", RDATA0, rd_m[0]);
    chk("rdata1", RDATA1, rd_m[1]);
    chk("done_ctl", {PSEL, PENABLE, GRANT}, 4'b0000);
    if (w == 1) REQ1 = 1'b0; else REQ0 = 1'b0;
    PREADY = timed; PSLVERR = 1'b0;
  endtask

  initial begin
    last_m = 1;
    rd_m[0] = 32'h0; rd_m[1] = 32'h0;
    repeat (3) step();
    chk("rst_ctl", {PSEL, PENABLE, PWRITE, GRANT}, 5'b0);
    chk("rst_ack_err", {ACK0, ACK1, ERR0, ERR1}, 4'b0);
    chk("rst_rdata", RDATA0 | RDATA1, 32'h0);
    chk("rst_payload", {PADDR, PWDATA, PSTRB}, 48'h0);
    PRESET = 1'b0;

    // Contention from reset: both held, winner re-requests in its ACK cycle.
    REQ0 = 1; ADDR0 = 12'h100; WRITE0 = 0;
    REQ1 = 1; ADDR1 = 12'h200; WRITE1 = 1; WDATA1 = 32'h11112222; STRB1 = 4'h3;
    for (int i = 0; i < 4; i++) begin
      run_xfer(i % 2, 1'b0, 32'hA000_0000 + i, order[i]);
      if (order[i] == 1) REQ1 = 1; else REQ0 = 1;
    end
    chk("rr_order0", order[0], 0);
    chk("rr_order1", order[1], 1);
    chk("rr_order2", order[2], 0);
    chk("rr_order3", order[3], 1);
    REQ0 = 0; REQ1 = 0;
    step();

    // Single read, zero wait.
    REQ0 = 1; ADDR0 = 12'h010; WRITE0 = 0;
    run_xfer(0, 1'b0, 32'hDEADBEEF, won);
    chk("read_rdata0", RDATA0, 32'hDEADBEEF);

    // Single write with two wait states.
    REQ1 = 1; ADDR1 = 12'h004; WRITE1 = 1; WDATA1 = 32'h000000A5; STRB1 = 4'hF;
    run_xfer(2, 1'b0, 32'h55AA55AA, won);

    // Slave error on a read.
    REQ0 = 1; ADDR0 = 12'h030; WRITE0 = 0;
    run_xfer(0, 1'b1, 32'hCAFE0001, won);

    // Timeout on a read, then a late PREADY while idle.
    REQ0 = 1; ADDR0 = 12'h020; WRITE0 = 0;
    run_xfer(TO + 2, 1'b0, 32'hFFFF0000, won);
    step();
    chk("late_pready_ctl", {PSEL, PENABLE, ACK0, ACK1, GRANT}, 6'b0);
    chk("idle_hold_paddr", PADDR, 12'h020);
    chk("idle_hold_rdata0", RDATA0, 32'h0);
    PREADY = 0;
    REQ1 = 1; ADDR1 = 12'h040; WRITE1 = 0;
    run_xfer(1, 1'b0, 32'h0BAD_F00D, won);

    // Reset during ACCESS abandons the transfer and restores LAST.
    REQ0 = 1; ADDR0 = 12'h050; WRITE0 = 0;
    step();
    step();
    chk("pre_rst_access", {PSEL, PENABLE, GRANT}, 4'b1101);
    PRESET = 1;
    step();
    chk("midrst_ctl", {PSEL, PENABLE, GRANT, ACK0, ACK1}, 6'b0);
    chk("midrst_rdata", RDATA0 | RDATA1, 32'h0);
    PRESET = 0;
    last_m = 1; rd_m[0] = 32'h0; rd_m[1] = 32'h0;
    REQ1 = 1; ADDR1 = 12'h060; WRITE1 = 0;
    run_xfer(0, 1'b0, 32'h1234_5678, won);
    chk("post_rst_tie", won, 0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      if (!REQ0 && $urandom_range(0, 1) == 1) begin
        REQ0 = 1; ADDR0 = 12'($urandom); WRITE0 = 1'($urandom);
        WDATA0 = $urandom; STRB0 = 4'($urandom);
      end
      if (!REQ1 && $urandom_range(0, 1) == 1) begin
        REQ1 = 1; ADDR1 = 12'($urandom); WRITE1 = 1'($urandom);
        WDATA1 = $urandom; STRB1 = 4'($urandom);
      end
      if (!REQ0 && !REQ1) begin
        REQ0 = 1; ADDR0 = 12'($urandom); WRITE0 = 1'($urandom);
        WDATA0 = $urandom; STRB0 = 4'($urandom);
      end
      run_xfer(($urandom_range(0, 1) == 1) ? $urandom_range(0, TO - 1) : $urandom_range(TO + 1, TO + 3),
               1'($urandom), $urandom, won);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_arb.md
# apb_master_arb

Two-requester APB master arbiter. It lets two on-chip requesters share one APB segment, such as the peripheral slots of the Cortex-M3 APB subsystem: for example, the AHB-to-APB bridge path and the MFCC/CNN feature engine's register-access port. It arbitrates round-robin, runs a protocol-correct APB SETUP/ACCESS sequence for the winner, and returns read data and the error status to that requester. A watchdog ends transfers that a slave stalls on.

## Interface
- TIMEOUT, 64: number of ACCESS cycles with PREADY=0 before forced termination. Range 1..255; 0 disables the watchdog.
- PCLK  in  1  single clock for all logic.
- PRESET  in  1  reset; synchronous, active-high.
- REQ0 / REQ1  in  1  transfer request. Held with its payload until the matching ACK.
- ADDR0 / ADDR1  in  12  byte address.
- WRITE0 / WRITE1  in  1  1 = write, 0 = read.
- WDATA0 / WDATA1  in  32  write data.
- STRB0 / STRB1  in  4  byte strobes (ignored on reads; PSTRB driven 0).
- ACK0 / ACK1  out  1  one-cycle completion pulse.
- RDATA0 / RDATA1  out  32  read data. Valid with ACK; held until the next read completion for that requester.
- ERR0 / ERR1  out  1  completion status. Valid with ACK only; 0 otherwise.
- PSEL, PENABLE, PWRITE  out  1  APB master controls.
- PADDR  out  12; PWDATA  out  32; PSTRB  out  4.
- PRDATA  in  32; PREADY  in  1; PSLVERR  in  1.
- GRANT  out  2  one-hot current owner; 00 when idle.

## Operation
- FSM states are IDLE, SETUP and ACCESS.
- IDLE:
  - If any REQ is high, pick the winner, latch its ADDR/WRITE/WDATA/STRB into the PADDR/PWRITE/PWDATA/PSTRB registers, set GRANT, and go to SETUP.
  - Otherwise stay in IDLE.
- Arbitration is round-robin over the LAST register (the last requester granted):
  - If only one REQ is high, that requester wins.
  - If both are high, the requester that is not LAST wins.
  - LAST resets to 1, so requester 0 wins the first tie.
  - LAST updates at grant.
- SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1.
  - If PREADY=1: complete the transfer.
    - Pulse ACK for the owner next cycle.
    - ERR = PSLVERR.
    - On a read, RDATA(owner) = PRDATA.
    - On a write, RDATA is unchanged.
    - Go to IDLE; PSEL and PENABLE go to 0.
  - If PREADY=0: increment the wait counter.
    - When the counter reaches TIMEOUT (TIMEOUT≠0), force completion: ACK with ERR=1.
    - On a read, RDATA(owner) = 0.
    - PSEL and PENABLE drop; go to IDLE.
    - A late PREADY is ignored.
- The wait counter is 8 bits and clears on entry to SETUP.
- PADDR, PWRITE, PWDATA and PSTRB hold their last values while idle.
- Payload changes from a requester after grant have no effect on the current transfer.
- The non-owner is never ACKed; its REQ stays pending until a later IDLE.
- The requester must drop REQ in its ACK cycle unless it is issuing a new transfer. If REQ is high in the ACK cycle, that cycle's payload is taken as a new request.
- Reset (any state): next edge forces IDLE.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, GRANT, ACKx, ERRx, RDATAx and the counter are all 0; LAST=1.
  - An in-flight transfer is abandoned with no ACK.

## Timing
- All outputs are registered.
- REQ is sampled high in IDLE at edge k. Then:
  - PSEL=1 from edge k+1.
  - PENABLE=1 from edge k+2.
  - If PREADY is sampled high at edge k+3, ACK, ERR and RDATA are valid in the cycle after edge k+3, and PSEL drops at the same edge.
- Minimum transfer is 3 cycles from request to ACK.
- Back-to-back transfers have 1 IDLE cycle between them; the next SETUP is at edge k+4.
- Each PREADY wait state adds 1 cycle.
- Timeout fires at the edge where the count reaches TIMEOUT: ACK arrives TIMEOUT+3 cycles after the request.
- PSEL/PENABLE are never both 0 for a cycle within a transfer, and PENABLE is never 1 without PSEL.

## Test plan
- Single read: REQ0, ADDR0=0x010, WRITE0=0; slave returns PRDATA=0xDEADBEEF with PREADY=1 immediately. Required: PSEL at k+1, PENABLE at k+2, ACK0 one cycle after k+3, RDATA0=0xDEADBEEF, ERR0=0, RDATA1 unchanged.
- Single write with wait states: REQ1, ADDR1=0x004, WDATA1=0x000000A5, STRB1=0xF; PREADY low for 2 ACCESS cycles. Required: PADDR/PWDATA/PSTRB stable throughout, ACK1 after 5 cycles, ERR1=0.
- Contention: REQ0 and REQ1 held high continuously for 4 transfers from reset. Required: grants in order 0,1,0,1; each ACK is a single cycle; one IDLE cycle between transfers.
- Slave error: PSLVERR=1 with PREADY on a read by requester 0. Required: ACK0 with ERR0=1, RDATA0=PRDATA.
- Timeout: TIMEOUT=4, PREADY held 0 on a read. Required: ACK0 at 7 cycles, ERR0=1, RDATA0=0, PSEL/PENABLE drop; a late PREADY is ignored; the next request proceeds normally.
- Reset mid-ACCESS: assert PRESET for one cycle during ACCESS. Required: next edge gives PSEL=PENABLE=GRANT=0 with no ACK; after release, a tie grants requester 0.
